mac_operand_feeder: RTL and testbench
=====================================

MAC_OPERAND_FEEDER -- requirements
Module: mac_operand_feeder

Interface
REQ-001 Parameter N, default 4, meaning systolic array dimension (legal 2..8); IW = clog2(N).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 wr_en  in  1  operand write strobe.
REQ-005 wr_sel  in  1  0 = matrix A, 1 = matrix B.
REQ-006 wr_row, wr_col  in  IW each  element index.
REQ-007 wr_data  in  8  unsigned 8b element.
REQ-008 start  in  1  one-cycle pulse launching a matrix multiply.
REQ-009 busy  out  1  high from the cycle after an accepted start until done inclusive.
REQ-010 done  out  1  one-cycle pulse; end of operation.
REQ-011 a_lanes  out  8*N  lane i = bits [8i+7:8i], drives a_in of array row i, column 0.
REQ-012 b_lanes  out  8*N  lane j, drives b_in of array column j, row 0.
REQ-013 load_en, mult_en, acc_en  out  1 each  broadcast MAC enables.
REQ-014 mac_clear  out  1  one-cycle clear pulse to all MAC reset inputs.

Function
REQ-015 The block SHALL hold two N x N 8b operand stores, A and B, written only when wr_en=1 and busy=0; writes while busy SHALL be ignored.
REQ-016 All outputs SHALL be registered; no combinational input-to-output path.
REQ-017 FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-018 IDLE -> CLEAR when start=1; start while busy SHALL be ignored.
REQ-019 A write and start in the same IDLE cycle SHALL both take effect; the written value SHALL be used by the operation.
REQ-020 CLEAR: exactly 1 cycle, mac_clear=1, enables=0, lanes=0; then STREAM.
REQ-021 STREAM: exactly 2N-1 cycles, step s = 0..2N-2.
REQ-022 In step s, a lane i SHALL be A[i][s-i] if 0 <= s-i < N, else 0.
REQ-023 In step s, b lane j SHALL be B[s-j][j] if 0 <= s-j < N, else 0 (row/column skew).
REQ-024 DRAIN: exactly N+1 cycles, all lanes 0.
REQ-025 load_en, mult_en, acc_en SHALL be 1 in every STREAM and DRAIN cycle, 0 otherwise.
REQ-026 DONE: 1 cycle with done=1; then IDLE.
REQ-027 Total latency from start cycle to done: 3N+2 cycles (N=4: 14).
REQ-028 busy SHALL be 1 in CLEAR, STREAM, DRAIN, DONE; 0 in IDLE.
REQ-029 Operand stores SHALL retain contents across operations; repeat start without writes SHALL reproduce identical lane streams.
REQ-030 Step counter SHALL wrap/reset to 0 on every state entry; no step value outside 0..2N-2 observed in STREAM.
REQ-031 Out-of-range wr_row/wr_col (>= N, non-power-of-two N) SHALL be ignored.
REQ-032 Array result: after done, MAC(i,j) acc_out = sum over k of A[i][k]*B[k][j], 32b, no overflow for 8b operands, N <= 8.

Reset
REQ-033 On reset=1 at a clock edge: state IDLE, counters 0, busy=0, done=0, mac_clear=0, all enables 0, a_lanes=0, b_lanes=0.
REQ-034 Reset mid-operation SHALL abort immediately to IDLE with no done pulse; operand store contents need not be cleared.
REQ-035 reset SHALL take priority over start and wr_en in the same cycle.

Verification
REQ-036 N=4, A=identity, B[r][c]=4r+c+1, start -> mac_clear at cycle 1, done at cycle 14, MAC(i,j) holds B[i][j].
REQ-037 A and B all 255, start -> every MAC acc_out = 4*65025 = 260100.
REQ-038 Step trace: A[i][k]=16i+k -> a lane 2 reads 0,0,0x20,0x21,0x22,0x23,0 over steps 0..6.
REQ-039 Write A[0][0]=9 while busy, then second start -> lane 0 step 0 still shows prior value; rerun yields identical results.
REQ-040 reset asserted in STREAM step 3 -> next cycle busy=0, all outputs 0, no done; fresh start completes normally.
REQ-041 start held high 20 cycles -> exactly one operation, then a second starts from IDLE cycle 15.

Source files
------------

// File: rtl/mac_operand_feeder.sv
// Operand feeder for an N x N systolic MAC array: holds matrices A and B and
// streams them row/column-skewed into the array edges under a small FSM.
module mac_operand_feeder #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [IW-1:0]   wr_row,
  input  logic [IW-1:0]   wr_col,
  input  logic [7:0]      wr_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [8*N-1:0]  a_lanes,
  output logic [8*N-1:0]  b_lanes,
  output logic            load_en,
  output logic            mult_en,
  output logic            acc_en,
  output logic            mac_clear
);

  localparam int SW = $clog2(2 * N);
  localparam logic [IW:0] NLIM = (IW + 1)'(N);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            clear_q, clear_d;
  logic            en_q, en_d;
  logic [8*N-1:0]  aLanes_q, aLanes_d;
  logic [8*N-1:0]  bLanes_q, bLanes_d;
  logic [7:0]      aMem_q [N][N];
  logic [7:0]      bMem_q [N][N];
  logic            wrOk;

  // Stores only accept writes while idle; indices beyond N-1 are dropped.
  assign wrOk = wr_en && !busy_q && ({1'b0, wr_row} < NLIM) && ({1'b0, wr_col} < NLIM);

  always_ff @(posedge clk) begin
    if (!reset && wrOk) begin
      if (wr_sel) begin
        bMem_q[wr_row][wr_col] <= wr_data;
      end else begin
        aMem_q[wr_row][wr_col] <= wr_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          step_d  = '0;
        end
      end
      CLEAR: begin
        state_d = STREAM;
        step_d  = '0;
      end
      STREAM: begin
        if (step_q == SW'(2 * N - 2)) begin
          state_d = DRAIN;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DRAIN: begin
        if (step_q == SW'(N)) begin
          state_d = DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        step_d  = '0;
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the cycle of that state.
  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    clear_d  = (state_d == CLEAR);
    en_d     = (state_d == STREAM) || (state_d == DRAIN);
    aLanes_d = '0;
    bLanes_d = '0;
    if (state_d == STREAM) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(step_d) == i + k) begin
            aLanes_d[8*i +: 8] = aMem_q[IW'(i)][IW'(k)];
            bLanes_d[8*i +: 8] = bMem_q[IW'(k)][IW'(i)];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clear_q  <= 1'b0;
      en_q     <= 1'b0;
      aLanes_q <= '0;
      bLanes_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      clear_q  <= clear_d;
      en_q     <= en_d;
      aLanes_q <= aLanes_d;
      bLanes_q <= bLanes_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mac_clear = clear_q;
  assign load_en   = en_q;
  assign mult_en   = en_q;
  assign acc_en    = en_q;
  assign a_lanes   = aLanes_q;
  assign b_lanes   = bLanes_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Testbench for mac_operand_feeder: lane/control trace model plus a behavioural
// systolic array whose accumulators are compared against the matrix product.
module tb_mac_operand_feeder;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset, wr_en, wr_sel, start;
  logic [1:0]     wr_row, wr_col;
  logic [7:0]     wr_data;
  logic           busy, done, load_en, mult_en, acc_en, mac_clear;
  logic [8*N-1:0] a_lanes, b_lanes;

  always #5 clk = ~clk;

  mac_operand_feeder #(.N(N)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
    .busy(busy), .done(done), .a_lanes(a_lanes), .b_lanes(b_lanes),
    .load_en(load_en), .mult_en(mult_en), .acc_en(acc_en), .mac_clear(mac_clear)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  mA [N][N];
  logic [7:0]  mB [N][N];
  logic [31:0] acc [N][N];
  logic [7:0]  pa [N][N];
  logic [7:0]  pb [N][N];
  logic [7:0]  ai, bi;
  logic [7:0]  aTrace [7];
  logic [7:0]  lane0Step0;

  typedef struct {
    int          aMode;
    int          bMode;
    logic [31:0] c00;
    logic [31:0] c33;
  } vec_t;

  // Behavioural array: a flows right, b flows down, every PE accumulates a*b.
  always @(negedge clk) begin
    if (mac_clear) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] = '0; pa[i][j] = '0; pb[i][j] = '0;
        end
    end else if (acc_en) begin
      for (int i = N - 1; i >= 0; i--)
        for (int j = N - 1; j >= 0; j--) begin
          if (j == 0) ai = a_lanes[8*i +: 8];
          else        ai = pa[i][j-1];
          if (i == 0) bi = b_lanes[8*j +: 8];
          else        bi = pb[i-1][j];
          acc[i][j] = acc[i][j] + 32'(ai) * 32'(bi);
          pa[i][j]  = ai;
          pb[i][j]  = bi;
        end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int mode, input int r, input int c);
    case (mode)
      0:       return (r == c) ? 8'd1 : 8'd0;
      1:       return 8'(4 * r + c + 1);
      2:       return 8'd255;
      default: return 8'(16 * r + c);
    endcase
  endfunction

  function automatic logic [31:0] laneModel(input bit isB, input int s);
    logic [31:0] r;
    int k;
    r = '0;
    for (int i = 0; i < N; i++) begin
      k = s - i;
      if (k >= 0 && k < N) r[8*i +: 8] = isB ? mB[k][i] : mA[i][k];
    end
    return r;
  endfunction

  task automatic writeElem(input bit sel, input int r, input int c, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
    if (sel) mB[r][c] = d;
    else     mA[r][c] = d;
  endtask

  task automatic loadMatrix(input bit sel, input int mode);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) writeElem(sel, r, c, pat(mode, r, c));
  endtask

  // One full operation: start in cycle 0, then check every cycle up to the first idle cycle.
  task automatic applyStimulus(input int busyWrCycle, input bit sameWr, input bit wsel,
                               input int wr, input int wc, input logic [7:0] wd);
    logic [31:0] expA, expB, sum;
    logic [5:0]  expCtrl;
    int s;
    @(negedge clk);
    start = 1'b1; wr_en = sameWr; wr_sel = wsel; wr_row = 2'(wr); wr_col = 2'(wc); wr_data = wd;
    if (sameWr) begin
      if (wsel) mB[wr][wc] = wd;
      else      mA[wr][wc] = wd;
    end
    for (int t = 1; t <= 15; t++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      if (t == busyWrCycle) begin
        wr_en = 1'b1; wr_sel = wsel; wr_row = 2'(wr); wr_col = 2'(wc); wr_data = wd;
      end
      s = t - 2;
      expA = '0; expB = '0;
      if (t >= 2 && t <= 8) begin
        expA = laneModel(1'b0, s);
        expB = laneModel(1'b1, s);
        aTrace[s] = a_lanes[23:16];
        if (s == 0) lane0Step0 = a_lanes[7:0];
      end
      expCtrl = {t <= 14, t == 14, t == 1, {3{t >= 2 && t <= 13}}};
      checkOutput($sformatf("ctrl@%0d", t),
                  {26'b0, busy, done, mac_clear, load_en, mult_en, acc_en}, {26'b0, expCtrl});
      checkOutput($sformatf("aLanes@%0d", t), a_lanes, expA);
      checkOutput($sformatf("bLanes@%0d", t), b_lanes, expB);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        sum = '0;
        for (int k = 0; k < N; k++) sum = sum + 32'(mA[i][k]) * 32'(mB[k][j]);
        checkOutput($sformatf("acc%0d%0d", i, j), acc[i][j], sum);
      end
  endtask

  initial begin
    vec_t        vecs [4];
    logic [7:0]  expTrace [7];
    int          doneCnt, clrCnt, busy15;
    int          doneAt [4];
    int          clrAt [4];

    vecs[0] = '{aMode: 0, bMode: 1, c00: 32'd1,      c33: 32'd16};
    vecs[1] = '{aMode: 2, bMode: 2, c00: 32'd260100, c33: 32'd260100};
    vecs[2] = '{aMode: 3, bMode: 0, c00: 32'd0,      c33: 32'd51};
    vecs[3] = '{aMode: 1, bMode: 2, c00: 32'd2550,   c33: 32'd14790};
    expTrace = '{8'h00, 8'h00, 8'h20, 8'h21, 8'h22, 8'h23, 8'h00};

    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; start = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("resetCtrl", {26'b0, busy, done, mac_clear, load_en, mult_en, acc_en}, 32'd0);
    checkOutput("resetA", a_lanes, 32'd0);
    checkOutput("resetB", b_lanes, 32'd0);
    reset = 1'b0;

    $display("[TB] table-driven matrix cases");
    for (int v = 0; v < 4; v++) begin
      loadMatrix(1'b0, vecs[v].aMode);
      loadMatrix(1'b1, vecs[v].bMode);
      applyStimulus(-1, 1'b0, 1'b0, 0, 0, 8'h00);
      checkOutput($sformatf("vec%0d_c00", v), acc[0][0], vecs[v].c00);
      checkOutput($sformatf("vec%0d_c33", v), acc[3][3], vecs[v].c33);
    end

    $display("[TB] reset priority over start and write");
    @(negedge clk);
    reset = 1'b1; start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd1; wr_col = 2'd1; wr_data = 8'hEE;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; wr_en = 1'b0;
    checkOutput("rstPrioBusy", {31'b0, busy}, 32'd0);
    applyStimulus(-1, 1'b0, 1'b0, 0, 0, 8'h00);

    $display("[TB] lane 2 step trace");
    loadMatrix(1'b0, 3);
    applyStimulus(-1, 1'b0, 1'b0, 0, 0, 8'h00);
    for (int s = 0; s < 7; s++) checkOutput($sformatf("trace%0d", s), 32'(aTrace[s]), 32'(expTrace[s]));

    $display("[TB] write while busy is ignored");
    writeElem(1'b0, 0, 0, 8'h5A);
    applyStimulus(3, 1'b0, 1'b0, 0, 0, 8'h09);
    checkOutput("busyWrRun1", 32'(lane0Step0), 32'h5A);
    applyStimulus(-1, 1'b0, 1'b0, 0, 0, 8'h00);
    checkOutput("busyWrRun2", 32'(lane0Step0), 32'h5A);

    $display("[TB] write and start in the same cycle");
    applyStimulus(-1, 1'b1, 1'b1, 2, 1, 8'hC3);

    $display("[TB] reset during STREAM step 3");
    @(negedge clk);
    start = 1'b1; wr_en = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t == 5) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abortCtrl", {26'b0, busy, done, mac_clear, load_en, mult_en, acc_en}, 32'd0);
    checkOutput("abortA", a_lanes, 32'd0);
    checkOutput("abortB", b_lanes, 32'd0);
    doneCnt = 0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("abortNoDone", 32'(doneCnt), 32'd0);
    applyStimulus(-1, 1'b0, 1'b0, 0, 0, 8'h00);

    $display("[TB] start held high for 20 cycles");
    doneCnt = 0; clrCnt = 0; busy15 = -1;
    for (int t = 0; t <= 40; t++) begin
      @(negedge clk);
      if (t >= 1) begin
        if (done) begin
          if (doneCnt < 4) doneAt[doneCnt] = t;
          doneCnt++;
        end
        if (mac_clear) begin
          if (clrCnt < 4) clrAt[clrCnt] = t;
          clrCnt++;
        end
        if (t == 15) busy15 = int'(busy);
      end
      wr_en = 1'b0;
      start = (t < 20);
    end
    start = 1'b0;
    checkOutput("holdDoneCnt", 32'(doneCnt), 32'd2);
    checkOutput("holdClrCnt", 32'(clrCnt), 32'd2);
    checkOutput("holdBusy15", 32'(busy15), 32'd0);
    if (doneCnt >= 2 && clrCnt >= 2) begin
      checkOutput("holdDone0", 32'(doneAt[0]), 32'd14);
      checkOutput("holdDone1", 32'(doneAt[1]), 32'd29);
      checkOutput("holdClr0", 32'(clrAt[0]), 32'd1);
      checkOutput("holdClr1", 32'(clrAt[1]), 32'd16);
    end

    $display("[TB] randomized operands");
    for (int it = 0; it < 4; it++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          writeElem(1'b0, r, c, 8'($urandom_range(0, 255)));
          writeElem(1'b1, r, c, 8'($urandom_range(0, 255)));
        end
      applyStimulus((it % 2 == 1) ? int'($urandom_range(1, 14)) : -1, (it % 2 == 0),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
